// File: rtl/mips_pkg.sv
// +------------------------------------------------------------------+
// | mips_pkg: shared opcodes, NOP encoding and width defaults          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mips_pkg;
  localparam logic [5:0]  OPC_J       = 6'b000010;
  localparam logic [5:0]  OPC_JAL     = 6'b000011;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          DEF_PC_W    = 10;
  localparam int          DEF_INSTR_W = 32;
endpackage

`default_nettype wire

// File: rtl/jump_detect.sv
// +------------------------------------------------------------------+
// | jump_detect: flags a valid J/JAL opcode                           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module jump_detect
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       valid,
  output logic       jump
);

  assign jump = valid && ((opcode == OPC_J) || (opcode == OPC_JAL));

endmodule

`default_nettype wire

// File: rtl/if_id_latch.sv
// +------------------------------------------------------------------+
// | if_id_latch: IF/ID pipeline register with stall, flush and jump   |
// | squash. Optional macro IFID_PERF_EN adds stall/flush counters.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module if_id_latch
  import mips_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
`ifdef IFID_PERF_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [PC_W-1:0]    PC,
  input  logic               hazardFlag,
  input  logic               branchFlag,
  output logic [INSTR_W-1:0] instr_id,
  output logic [PC_W-1:0]    pc_id,
  output logic               valid_id,
  output logic [5:0]         opcjump,
  output logic [PC_W-1:0]    jumpPC,
  output logic               jumpFlag
`ifdef IFID_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
`endif
);

  logic [INSTR_W-1:0] instr_r;
  logic [PC_W-1:0]    pc_r;
  logic               valid_r;
  logic               squash_r;
  logic               fetch_is_jump;

  // A jump captured into ID arms the squash of the sequential word behind it.
  jump_detect u_fetch_jump (
    .opcode (Instruction[INSTR_W-1 -: 6]),
    .valid  (1'b1),
    .jump   (fetch_is_jump)
  );

  jump_detect u_id_jump (
    .opcode (instr_r[INSTR_W-1 -: 6]),
    .valid  (valid_r),
    .jump   (jumpFlag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r  <= '0;
      pc_r     <= '0;
      valid_r  <= 1'b0;
      squash_r <= 1'b0;
    end else if (branchFlag || (!hazardFlag && squash_r)) begin
      instr_r  <= INSTR_W'(NOP_INSTR);
      pc_r     <= PC;
      valid_r  <= 1'b0;
      squash_r <= 1'b0;
    end else if (!hazardFlag) begin
      instr_r  <= Instruction;
      pc_r     <= PC;
      valid_r  <= 1'b1;
      squash_r <= fetch_is_jump;
    end
  end

  assign instr_id = instr_r;
  assign pc_id    = pc_r;
  assign valid_id = valid_r;
  assign opcjump  = instr_r[INSTR_W-1 -: 6];
  assign jumpPC   = instr_r[PC_W-1:0];

`ifdef IFID_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = hazardFlag && !branchFlag;
  assign flush_evt = branchFlag || (!hazardFlag && squash_r);

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_evt && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_latch.sv
// +------------------------------------------------------------------+
// | tb_if_id_latch: vector-table bench for if_id_latch                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_if_id_latch;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction;
  logic [9:0]  PC;
  logic        hazardFlag;
  logic        branchFlag;
  logic [31:0] instr_id;
  logic [9:0]  pc_id;
  logic        valid_id;
  logic [5:0]  opcjump;
  logic [9:0]  jumpPC;
  logic        jumpFlag;
`ifdef IFID_PERF_EN
  logic [3:0]  stall_count;
  logic [3:0]  flush_count;
`endif

  int total = 0;
  int bad   = 0;

  if_id_latch #(
    .PC_W    (10),
    .INSTR_W (32)
`ifdef IFID_PERF_EN
    ,
    .CNT_W   (4)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .PC          (PC),
    .hazardFlag  (hazardFlag),
    .branchFlag  (branchFlag),
    .instr_id    (instr_id),
    .pc_id       (pc_id),
    .valid_id    (valid_id),
    .opcjump     (opcjump),
    .jumpPC      (jumpPC),
    .jumpFlag    (jumpFlag)
`ifdef IFID_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        haz;
    logic        br;
    logic [31:0] e_instr;
    logic [9:0]  e_pc;
    logic        e_valid;
    logic        e_jf;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] e_instr, input logic [9:0] e_pc,
                             input logic e_valid, input logic e_jf);
    logic [31:0] ei;
    ei = e_instr;
    chk({tag, " instr_id"}, instr_id, e_instr);
    chk({tag, " pc_id"}, 32'(pc_id), 32'(e_pc));
    chk({tag, " valid_id"}, 32'(valid_id), 32'(e_valid));
    chk({tag, " jumpFlag"}, 32'(jumpFlag), 32'(e_jf));
    chk({tag, " opcjump"}, 32'(opcjump), 32'(ei[31:26]));
    chk({tag, " jumpPC"}, 32'(jumpPC), 32'(ei[9:0]));
  endtask

  initial begin
    // instr, pc, haz, br -> expected instr, pc, valid, jumpFlag
    v[0]  = '{32'h2002_0005, 10'd3,    1'b0, 1'b0, 32'h2002_0005, 10'd3,    1'b1, 1'b0};
    v[1]  = '{32'h8C01_0004, 10'd4,    1'b0, 1'b0, 32'h8C01_0004, 10'd4,    1'b1, 1'b0};
    v[2]  = '{32'h1111_1111, 10'd5,    1'b1, 1'b0, 32'h8C01_0004, 10'd4,    1'b1, 1'b0};
    v[3]  = '{32'h2222_2222, 10'd6,    1'b1, 1'b0, 32'h8C01_0004, 10'd4,    1'b1, 1'b0};
    v[4]  = '{32'h3333_3333, 10'd7,    1'b1, 1'b0, 32'h8C01_0004, 10'd4,    1'b1, 1'b0};
    v[5]  = '{32'h3333_3333, 10'd7,    1'b0, 1'b0, 32'h3333_3333, 10'd7,    1'b1, 1'b0};
    v[6]  = '{32'h0022_1820, 10'd7,    1'b0, 1'b1, 32'h0000_0000, 10'd7,    1'b0, 1'b0};
    v[7]  = '{32'h0800_0012, 10'd4,    1'b0, 1'b0, 32'h0800_0012, 10'd4,    1'b1, 1'b1};
    v[8]  = '{32'h8C01_00AA, 10'd5,    1'b0, 1'b0, 32'h0000_0000, 10'd5,    1'b0, 1'b0};
    v[9]  = '{32'h2002_0012, 10'h012,  1'b0, 1'b0, 32'h2002_0012, 10'h012,  1'b1, 1'b0};
    v[10] = '{32'h0C00_0020, 10'h013,  1'b0, 1'b0, 32'h0C00_0020, 10'h013,  1'b1, 1'b1};
    v[11] = '{32'h0000_0011, 10'h021,  1'b1, 1'b0, 32'h0C00_0020, 10'h013,  1'b1, 1'b1};
    v[12] = '{32'h0000_AAAA, 10'h022,  1'b1, 1'b1, 32'h0000_0000, 10'h022,  1'b0, 1'b0};
    v[13] = '{32'h2003_0001, 10'h030,  1'b0, 1'b0, 32'h2003_0001, 10'h030,  1'b1, 1'b0};
    v[14] = '{32'h0000_0001, 10'h031,  1'b1, 1'b1, 32'h0000_0000, 10'h031,  1'b0, 1'b0};
    v[15] = '{32'h0800_0005, 10'h032,  1'b0, 1'b0, 32'h0800_0005, 10'h032,  1'b1, 1'b1};
    v[16] = '{32'h0000_0002, 10'h033,  1'b0, 1'b0, 32'h0000_0000, 10'h033,  1'b0, 1'b0};
    v[17] = '{32'h2004_0002, 10'h005,  1'b0, 1'b0, 32'h2004_0002, 10'h005,  1'b1, 1'b0};

    reset       = 1'b0;
    Instruction = 32'h0;
    PC          = 10'd0;
    hazardFlag  = 1'b0;
    branchFlag  = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("reset", 32'h0, 10'd0, 1'b0, 1'b0);
`ifdef IFID_PERF_EN
    chk("reset stall_count", 32'(stall_count), 32'd0);
    chk("reset flush_count", 32'(flush_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      Instruction = v[i].instr;
      PC          = v[i].pc;
      hazardFlag  = v[i].haz;
      branchFlag  = v[i].br;
      @(posedge clk);
      #1;
      chk_outputs($sformatf("vec%0d", i), v[i].e_instr, v[i].e_pc, v[i].e_valid, v[i].e_jf);
    end
`ifdef IFID_PERF_EN
    chk("stall_count after table", 32'(stall_count), 32'd4);
    chk("flush_count after table", 32'(flush_count), 32'd5);
`endif

    // Asynchronous reset mid-stream, then first capture after release.
    Instruction = 32'h8C01_0004;
    PC          = 10'd8;
    hazardFlag  = 1'b0;
    branchFlag  = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("pre-reset load", 32'h8C01_0004, 10'd8, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs("async reset", 32'h0, 10'd0, 1'b0, 1'b0);
`ifdef IFID_PERF_EN
    chk("async reset stall_count", 32'(stall_count), 32'd0);
    chk("async reset flush_count", 32'(flush_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk_outputs("reset held", 32'h0, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset       = 1'b1;
    Instruction = 32'h2002_0005;
    PC          = 10'd3;
    @(posedge clk);
    #1;
    chk_outputs("post-reset load", 32'h2002_0005, 10'd3, 1'b1, 1'b0);

    // Long stall: contents hold; the 4-bit stall counter saturates.
    hazardFlag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Instruction = 32'h4000_0000 + 32'(i);
      PC          = 10'(100 + i);
      @(posedge clk);
      #1;
    end
    chk_outputs("long stall", 32'h2002_0005, 10'd3, 1'b1, 1'b0);
`ifdef IFID_PERF_EN
    chk("stall_count saturated", 32'(stall_count), 32'd15);
    chk("flush_count unchanged", 32'(flush_count), 32'd0);
`endif
    hazardFlag = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("stall release", 32'h4000_0013, 10'd119, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
